noc_chip_link: RTL and testbench

// Chip-boundary link adapter attached to one edge port of the NoC mesh (E/N/W/S boundary).
// TX: accepts FW-bit flits from the mesh edge port, buffers them, serializes onto an LW-bit off-chip link.
// RX: deserializes off-chip beats into flits, injects them into the mesh edge port under credit flow control.
// One instance per boundary port; the off-chip link uses a per-beat valid/ready handshake.

---
 rtl/noc_link_pkg.sv | 17 +
 rtl/noc_link_fifo.sv | 53 +++++
 rtl/noc_chip_link.sv | 170 +++++++++++++++++
 tb/tb_noc_chip_link.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/noc_link_pkg.sv
// Shared types and helpers for the NoC chip-boundary link adapter.
package noc_link_pkg;

   typedef enum logic [0:0] {
      TX_IDLE,
      TX_SEND
   } tx_state_t;

   localparam int ERR_FIFO_OVF  = 0;
   localparam int ERR_RX_RESYNC = 1;
   localparam int ERR_CRD_OVF   = 2;

   function automatic int nbeat(input int fw, input int lw);
      return (fw + lw - 1) / lw;
   endfunction

endpackage

// File: rtl/noc_link_fifo.sv
// Synchronous W x D flit FIFO; a write on full is accepted only when a read frees a slot that cycle.
module noc_link_fifo #(
   parameter int W = 36,
   parameter int D = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         wr,
   input  logic [W-1:0] din,
   input  logic         rd,
   output logic [W-1:0] dout,
   output logic         full,
   output logic         empty
);
   localparam int AW = (D > 1) ? $clog2(D) : 1;
   localparam logic [AW-1:0] PTR_LAST = AW'(D - 1);
   localparam logic [AW:0]   CNT_FULL = (AW + 1)'(D);
   localparam logic [AW:0]   CNT_ONE  = (AW + 1)'(1);

   logic [W-1:0]  mem [D];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW:0]   count;
   logic          do_rd;
   logic          do_wr;

   assign full  = (count == CNT_FULL);
   assign empty = (count == '0);
   assign do_rd = rd && !empty;
   assign do_wr = wr && (!full || do_rd);
   assign dout  = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (do_wr) mem[wr_ptr] <= din;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_wr) wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + AW'(1);
         if (do_rd) rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + AW'(1);
         case ({do_wr, do_rd})
            2'b10:   count <= count + CNT_ONE;
            2'b01:   count <= count - CNT_ONE;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/noc_chip_link.sv
// Chip-boundary link adapter: TX flit FIFO + beat serializer, RX deserializer with credit-gated mesh injection.
//   state   | meaning
//   TX_IDLE | shift register empty, waiting for a buffered flit
//   TX_SEND | driving beats of the current flit onto the off-chip link
module noc_chip_link
   import noc_link_pkg::*;
#(
   parameter int FW = 36,
   parameter int LW = 9,
   parameter int B  = 4
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          flit_in_wr,
   input  logic [FW-1:0] flit_in,
   output logic          credit_out,
   output logic          flit_out_wr,
   output logic [FW-1:0] flit_out,
   input  logic          credit_in,
   output logic [LW-1:0] tx_data,
   output logic          tx_sof,
   output logic          tx_valid,
   input  logic          tx_ready,
   input  logic [LW-1:0] rx_data,
   input  logic          rx_sof,
   input  logic          rx_valid,
   output logic          rx_ready,
   output logic [2:0]    err
);
   localparam int NB = nbeat(FW, LW);
   localparam int PW = NB * LW;
   localparam int CW = (NB > 1) ? $clog2(NB) : 1;
   localparam int KW = $clog2(B + 1);
   localparam logic [CW-1:0] BEAT_LAST = CW'(NB - 1);
   localparam logic [KW-1:0] CRD_MAX   = KW'(B);

   tx_state_t     tx_state;
   logic [CW-1:0] tx_cnt;
   logic [PW-1:0] tx_shreg;
   logic [FW-1:0] fifo_dout;
   logic          fifo_full;
   logic          fifo_empty;
   logic          tx_last_hs;
   logic          tx_pop;
   logic          fifo_ovf;

   logic [CW-1:0] rx_cnt;
   logic [PW-1:0] rx_buf;
   logic [PW-1:0] rx_next;
   logic [CW-1:0] rx_idx;
   logic          rx_acc;
   logic          rx_drop;
   logic          rx_resync;
   logic          hold_valid;
   logic [FW-1:0] hold_data;
   logic [KW-1:0] crd_cnt;
   logic          inject;
   logic          crd_ovf;

   noc_link_fifo #(.W(FW), .D(B)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .wr    (flit_in_wr),
      .din   (flit_in),
      .rd    (tx_pop),
      .dout  (fifo_dout),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   // Popping on the last handshake lets back-to-back flits stream without a bubble.
   assign tx_last_hs = (tx_state == TX_SEND) && tx_ready && (tx_cnt == BEAT_LAST);
   assign tx_pop     = !fifo_empty && ((tx_state == TX_IDLE) || tx_last_hs);
   assign fifo_ovf   = flit_in_wr && fifo_full && !tx_pop;

   assign tx_valid = (tx_state == TX_SEND);
   assign tx_sof   = (tx_state == TX_SEND) && (tx_cnt == '0);
   assign tx_data  = tx_shreg[LW-1:0];

   always_ff @(posedge clk) begin
      if (rst) begin
         tx_state   <= TX_IDLE;
         tx_cnt     <= '0;
         tx_shreg   <= '0;
         credit_out <= 1'b0;
      end else begin
         credit_out <= tx_pop;
         if (tx_pop) begin
            tx_state <= TX_SEND;
            tx_cnt   <= '0;
            tx_shreg <= PW'(fifo_dout);
         end else begin
            case (tx_state)
               TX_SEND: begin
                  if (tx_ready) begin
                     if (tx_cnt == BEAT_LAST) begin
                        tx_state <= TX_IDLE;
                        tx_cnt   <= '0;
                     end else begin
                        tx_cnt   <= tx_cnt + CW'(1);
                        tx_shreg <= tx_shreg >> LW;
                     end
                  end
               end
               default: tx_state <= TX_IDLE;
            endcase
         end
      end
   end

   // Beats enter at the top and shift down, so beat 0 lands in the LSB slice.
   assign rx_ready  = !hold_valid;
   assign rx_acc    = rx_valid && rx_ready;
   assign rx_drop   = !rx_sof && (rx_cnt == '0);
   assign rx_resync = rx_acc && (rx_sof ? (rx_cnt != '0) : (rx_cnt == '0));
   assign rx_idx    = rx_sof ? '0 : rx_cnt;
   assign rx_next   = (rx_buf >> LW) | ({{(PW - LW){1'b0}}, rx_data} << (PW - LW));
   assign inject    = hold_valid && (crd_cnt != '0);
   assign crd_ovf   = credit_in && !inject && (crd_cnt == CRD_MAX);

   always_ff @(posedge clk) begin
      if (rst) begin
         rx_cnt      <= '0;
         rx_buf      <= '0;
         hold_valid  <= 1'b0;
         hold_data   <= '0;
         flit_out_wr <= 1'b0;
         flit_out    <= '0;
      end else begin
         flit_out_wr <= inject;
         if (inject) begin
            flit_out   <= hold_data;
            hold_valid <= 1'b0;
         end
         if (rx_acc && !rx_drop) begin
            rx_buf <= rx_next;
            if (rx_idx == BEAT_LAST) begin
               rx_cnt     <= '0;
               hold_valid <= 1'b1;
               hold_data  <= rx_next[FW-1:0];
            end else begin
               rx_cnt <= rx_idx + CW'(1);
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         crd_cnt <= CRD_MAX;
      end else begin
         case ({inject, credit_in})
            2'b10:   crd_cnt <= crd_cnt - KW'(1);
            2'b01:   crd_cnt <= (crd_cnt == CRD_MAX) ? CRD_MAX : crd_cnt + KW'(1);
            default: crd_cnt <= crd_cnt;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         err <= '0;
      end else begin
         if (fifo_ovf)  err[ERR_FIFO_OVF]  <= 1'b1;
         if (rx_resync) err[ERR_RX_RESYNC] <= 1'b1;
         if (crd_ovf)   err[ERR_CRD_OVF]   <= 1'b1;
      end
   end

endmodule

// File: tb/tb_noc_chip_link.sv
// Directed bench for noc_chip_link: serializer timing, FIFO overflow, loopback with credits, RX resync, reset.
module tb_noc_chip_link;

   logic        clk = 1'b0;
   logic        rst;
   logic        flit_in_wr;
   logic [35:0] flit_in;
   logic        credit_out;
   logic        flit_out_wr;
   logic [35:0] flit_out;
   logic        credit_in;
   logic [8:0]  tx_data;
   logic        tx_sof;
   logic        tx_valid;
   logic        tx_ready;
   logic [8:0]  rx_data;
   logic        rx_sof;
   logic        rx_valid;
   logic        rx_ready;
   logic [2:0]  err;

   logic        loop;
   logic        tx_ready_d;
   logic [8:0]  rx_data_d;
   logic        rx_sof_d;
   logic        rx_valid_d;

   int          checks = 0;
   int          failures = 0;
   logic [35:0] rx_q [$];
   int          crd_pulses;

   always #5 clk = ~clk;

   assign rx_data  = loop ? tx_data  : rx_data_d;
   assign rx_sof   = loop ? tx_sof   : rx_sof_d;
   assign rx_valid = loop ? tx_valid : rx_valid_d;
   assign tx_ready = loop ? rx_ready : tx_ready_d;

   noc_chip_link #(.FW(36), .LW(9), .B(4)) dut (
      .clk         (clk),
      .rst         (rst),
      .flit_in_wr  (flit_in_wr),
      .flit_in     (flit_in),
      .credit_out  (credit_out),
      .flit_out_wr (flit_out_wr),
      .flit_out    (flit_out),
      .credit_in   (credit_in),
      .tx_data     (tx_data),
      .tx_sof      (tx_sof),
      .tx_valid    (tx_valid),
      .tx_ready    (tx_ready),
      .rx_data     (rx_data),
      .rx_sof      (rx_sof),
      .rx_valid    (rx_valid),
      .rx_ready    (rx_ready),
      .err         (err)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      flit_in_wr = 1'b0;
      credit_in = 1'b0;
      rx_valid_d = 1'b0;
      rx_sof_d = 1'b0;
      step();
      step();
      rst = 1'b0;
      rx_q.delete();
      crd_pulses = 0;
   endtask

   task automatic run_cycles(input int n);
      for (int i = 0; i < n; i++) begin
         step();
         if (flit_out_wr) rx_q.push_back(flit_out);
         if (credit_out) crd_pulses++;
      end
   endtask

   task automatic send_beat(input logic [8:0] d, input logic s);
      rx_data_d = d;
      rx_sof_d = s;
      rx_valid_d = 1'b1;
      step();
      rx_valid_d = 1'b0;
      rx_sof_d = 1'b0;
   endtask

   task automatic send_flit(input logic [35:0] f);
      send_beat(f[8:0], 1'b1);
      send_beat(f[17:9], 1'b0);
      send_beat(f[26:18], 1'b0);
      send_beat(f[35:27], 1'b0);
   endtask

   initial begin
      logic [35:0] f2 [6];
      logic [35:0] f3 [5];
      logic [35:0] asm_flit;
      logic [35:0] g;
      logic [35:0] h;
      logic [35:0] k;
      int nvalid, nsof, nbeat, nflit;
      bit done;

      f2 = '{36'h1_2345_6789, 36'hF_EDCB_A987, 36'h0_0F0F_0F0F,
             36'h5_A5A5_A5A5, 36'hA_0000_0005, 36'h7_7777_7777};
      f3 = '{36'h0_1111_2222, 36'h3_3333_4444, 36'hC_5555_6666,
             36'h8_7777_8888, 36'hE_9999_AAAA};
      loop = 1'b0;
      tx_ready_d = 1'b0;
      rx_data_d = '0;
      flit_in = '0;
      do_reset();

      // reset values
      chk("rst_tx_valid", tx_valid, 0);
      chk("rst_tx_sof", tx_sof, 0);
      chk("rst_tx_data", tx_data, 0);
      chk("rst_credit_out", credit_out, 0);
      chk("rst_flit_out_wr", flit_out_wr, 0);
      chk("rst_flit_out", flit_out, 0);
      chk("rst_rx_ready", rx_ready, 1);
      chk("rst_err", err, 0);
      chk("rst_crd", dut.crd_cnt, 4);

      // 1: single flit, LSB slice first
      tx_ready_d = 1'b1;
      flit_in_wr = 1'b1;
      flit_in = 36'h9_8765_4321;
      step();
      flit_in_wr = 1'b0;
      chk("t1_valid_t", tx_valid, 0);
      step();
      chk("t1_credit_t1", credit_out, 1);
      chk("t1_valid_t1", tx_valid, 1);
      chk("t1_beat0", tx_data, 9'h121);
      chk("t1_sof0", tx_sof, 1);
      step();
      chk("t1_credit_t2", credit_out, 0);
      chk("t1_beat1", tx_data, 9'h0A1);
      chk("t1_sof1", tx_sof, 0);
      step();
      chk("t1_beat2", tx_data, 9'h1D9);
      step();
      chk("t1_beat3", tx_data, 9'h130);
      chk("t1_sof3", tx_sof, 0);
      step();
      chk("t1_valid_end", tx_valid, 0);

      // 2: back-to-back writes under back-pressure; one flit in the shifter + 4 buffered, 6th dropped
      do_reset();
      tx_ready_d = 1'b0;
      for (int i = 0; i < 6; i++) begin
         flit_in_wr = 1'b1;
         flit_in = f2[i];
         step();
         if (i == 1) chk("t2_first_credit", credit_out, 1);
         if (i == 4) begin
            chk("t2_err_before_ovf", err, 0);
            chk("t2_fifo_full", dut.fifo_full, 1);
         end
      end
      flit_in_wr = 1'b0;
      chk("t2_err_ovf", err, 3'b001);
      chk("t2_hold_data", tx_data, 9'h189);
      chk("t2_hold_sof", tx_sof, 1);
      tx_ready_d = 1'b1;
      nvalid = 0; nsof = 0; nbeat = 0; nflit = 0; done = 0; crd_pulses = 0;
      asm_flit = '0;
      for (int i = 0; i < 40 && !done; i++) begin
         if (tx_valid) begin
            nvalid++;
            if (tx_sof) nsof++;
            asm_flit[nbeat*9 +: 9] = tx_data;
            nbeat++;
            if (nbeat == 4) begin
               if (nflit < 5) chk($sformatf("t2_flit%0d", nflit), asm_flit, f2[nflit]);
               nflit++;
               nbeat = 0;
            end
         end else begin
            done = 1;
         end
         if (credit_out) crd_pulses++;
         step();
      end
      chk("t2_valid_run", nvalid, 20);
      chk("t2_sof_count", nsof, 5);
      chk("t2_credit_pulses", crd_pulses, 4);

      // 3: loopback, no credit return
      do_reset();
      loop = 1'b1;
      for (int i = 0; i < 3; i++) begin
         flit_in_wr = 1'b1;
         flit_in = f3[i];
         step();
      end
      flit_in_wr = 1'b0;
      run_cycles(40);
      chk("t3_count3", rx_q.size(), 3);
      for (int i = 0; i < 3 && i < rx_q.size(); i++)
         chk($sformatf("t3_flit%0d", i), rx_q[i], f3[i]);
      chk("t3_crd1", dut.crd_cnt, 1);
      for (int i = 3; i < 5; i++) begin
         flit_in_wr = 1'b1;
         flit_in = f3[i];
         step();
      end
      flit_in_wr = 1'b0;
      run_cycles(30);
      chk("t3_count4", rx_q.size(), 4);
      if (rx_q.size() > 3) chk("t3_flit3", rx_q[3], f3[3]);
      chk("t3_crd0", dut.crd_cnt, 0);
      chk("t3_stall_ready", rx_ready, 0);
      credit_in = 1'b1;
      step();
      credit_in = 1'b0;
      chk("t3_crd_ret", dut.crd_cnt, 1);
      chk("t3_no_wr_yet", flit_out_wr, 0);
      step();
      chk("t3_inj_wr", flit_out_wr, 1);
      chk("t3_inj_flit", flit_out, f3[4]);
      chk("t3_inj_crd", dut.crd_cnt, 0);
      step();
      chk("t3_wr_pulse", flit_out_wr, 0);
      chk("t3_flit_retain", flit_out, f3[4]);
      chk("t3_ready_back", rx_ready, 1);
      chk("t3_err", err, 0);
      loop = 1'b0;

      // 4: resync on an early sof, then a lone non-sof beat
      do_reset();
      g = 36'h3_1415_9265;
      h = 36'hA_BCDE_F012;
      send_beat(g[8:0], 1'b1);
      send_beat(g[17:9], 1'b0);
      chk("t4_err_clean", err, 0);
      send_flit(h);
      chk("t4_err_resync", err, 3'b010);
      run_cycles(3);
      chk("t4_count", rx_q.size(), 1);
      if (rx_q.size() > 0) chk("t4_flit", rx_q[0], h);
      do_reset();
      send_beat(9'h1AA, 1'b0);
      chk("t4_drop_err", err, 3'b010);
      chk("t4_drop_cnt", dut.rx_cnt, 0);

      // 5: credit_in with injection (no change), then at B (saturate)
      do_reset();
      k = 36'h6_0606_0606;
      send_flit(k);
      credit_in = 1'b1;
      step();
      credit_in = 1'b0;
      chk("t5_coinc_wr", flit_out_wr, 1);
      chk("t5_coinc_flit", flit_out, k);
      chk("t5_coinc_crd", dut.crd_cnt, 4);
      chk("t5_coinc_err", err, 0);
      credit_in = 1'b1;
      step();
      credit_in = 1'b0;
      chk("t5_ovf_err", err, 3'b100);
      chk("t5_ovf_crd", dut.crd_cnt, 4);

      // 6: reset mid-serialization with a partial RX flit and a buffered TX flit
      do_reset();
      tx_ready_d = 1'b1;
      send_beat(9'h055, 1'b0);
      send_beat(9'h011, 1'b1);
      send_beat(9'h022, 1'b0);
      flit_in_wr = 1'b1;
      flit_in = 36'h9_8765_4321;
      step();
      flit_in = 36'h2_2222_2222;
      step();
      flit_in_wr = 1'b0;
      step();
      step();
      chk("t6_pre_beat2", tx_data, 9'h1D9);
      chk("t6_pre_err", err, 3'b010);
      chk("t6_pre_rxcnt", dut.rx_cnt, 2);
      chk("t6_pre_fifo", dut.fifo_empty, 0);
      rst = 1'b1;
      step();
      chk("t6_tx_valid", tx_valid, 0);
      chk("t6_rx_ready", rx_ready, 1);
      chk("t6_crd", dut.crd_cnt, 4);
      chk("t6_err", err, 0);
      chk("t6_fifo_empty", dut.fifo_empty, 1);
      chk("t6_rxcnt", dut.rx_cnt, 0);
      rst = 1'b0;
      rx_q.delete();
      run_cycles(6);
      chk("t6_quiet_valid", tx_valid, 0);
      chk("t6_quiet_flits", rx_q.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

endmodule
